led_code_encoder: RTL and testbench

LED_CODE_ENCODER -- requirements
Module: led_code_encoder

---
 rtl/led_enc_pkg.sv | 30 +++
 rtl/led_code_encoder_if.sv | 11 +
 rtl/led_enc_slot_alloc.sv | 36 +++
 rtl/led_code_encoder.sv | 158 +++++++++++++++
 tb/tb_led_code_encoder.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/led_enc_pkg.sv
// Shared constants and types for the LED code encoder: per-LED 3-bit codes,
// the idle code and the frame state enum.
package led_enc_pkg;

    localparam int unsigned LED_N  = 4;
    localparam int unsigned CODE_W = 3;
    localparam int unsigned CNT_W  = 8;

    localparam logic [CODE_W-1:0] LED0_CODE = 3'b010;
    localparam logic [CODE_W-1:0] LED1_CODE = 3'b000;
    localparam logic [CODE_W-1:0] LED2_CODE = 3'b111;
    localparam logic [CODE_W-1:0] LED3_CODE = 3'b101;
    localparam logic [CODE_W-1:0] IDLE_CODE = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SLOT0 = 2'd1,
        ST_SLOT1 = 2'd2
    } state_e;

    function automatic logic [CODE_W-1:0] led_code(input logic [1:0] idx);
        case (idx)
            2'd0:    led_code = LED0_CODE;
            2'd1:    led_code = LED1_CODE;
            2'd2:    led_code = LED2_CODE;
            default: led_code = LED3_CODE;
        endcase
    endfunction

endpackage

// File: rtl/led_code_encoder_if.sv
// Request handshake between an LED mask producer and the encoder.
interface led_code_encoder_if;
    import led_enc_pkg::*;

    logic [LED_N-1:0] req_mask;
    logic             req_valid;
    logic             req_ready;

    modport master (output req_mask, output req_valid, input  req_ready);
    modport slave  (input  req_mask, input  req_valid, output req_ready);
endinterface

// File: rtl/led_enc_slot_alloc.sv
// Combinational allocator: packs the set bits of a mask, lowest index first,
// into slot0/chA, slot0/chB, slot1/chA, slot1/chB; unused channels idle.
module led_enc_slot_alloc
    import led_enc_pkg::*;
(
    input  logic [LED_N-1:0]  i_mask,
    output logic [CODE_W-1:0] o_s0a_c,
    output logic [CODE_W-1:0] o_s0b_c,
    output logic [CODE_W-1:0] o_s1a_c,
    output logic [CODE_W-1:0] o_s1b_c,
    output logic              o_two_slot_c
);

    logic [CODE_W-1:0] w_code [4];
    logic [2:0]        w_cnt;

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            w_code[j] = IDLE_CODE;
        end
        w_cnt = 3'd0;
        for (int i = 0; i < int'(LED_N); i++) begin
            if (i_mask[i]) begin
                w_code[w_cnt[1:0]] = led_code(2'(i));
                w_cnt              = w_cnt + 3'd1;
            end
        end
    end

    assign o_s0a_c      = w_code[0];
    assign o_s0b_c      = w_code[1];
    assign o_s1a_c      = w_code[2];
    assign o_s1b_c      = w_code[3];
    assign o_two_slot_c = (w_cnt > 3'd2);

endmodule

// File: rtl/led_code_encoder.sv
// Two-channel LED code encoder: time-multiplexes up to four LEDs over one or
// two slots of DWELL cycles each. Optional macro LED_ENC_BLANK_EN inserts a
// one-cycle idle blank before every slot entry that does not come from IDLE.
module led_code_encoder
    import led_enc_pkg::*;
#(
    parameter int unsigned DWELL = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    led_code_encoder_if.slave  bus,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               d,
    output logic               e,
    output logic               f,
    output logic               busy
);

`ifdef LED_ENC_BLANK_EN
    localparam logic BLANK_EN = 1'b1;
`else
    localparam logic BLANK_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    state_e             r_state;
    logic [LED_N-1:0]   r_mask;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_blank;
    logic [CODE_W-1:0]  r_cha;
    logic [CODE_W-1:0]  r_chb;
    logic               r_busy;

    state_e             w_nxt_state;
    logic [LED_N-1:0]   w_nxt_mask;
    logic [CNT_W-1:0]   w_nxt_cnt;
    logic               w_nxt_blank;
    logic [CODE_W-1:0]  w_nxt_cha;
    logic [CODE_W-1:0]  w_nxt_chb;

    logic [CODE_W-1:0]  w_s0a, w_s0b, w_s1a, w_s1b;
    logic               w_two_slot;
    logic               w_slot_last;
    logic               w_frame_last;
    logic               w_req_ready_c;
    logic               w_xfer;

    led_enc_slot_alloc u_alloc (
        .i_mask       (r_mask),
        .o_s0a_c      (w_s0a),
        .o_s0b_c      (w_s0b),
        .o_s1a_c      (w_s1a),
        .o_s1b_c      (w_s1b),
        .o_two_slot_c (w_two_slot)
    );

    // A blank cycle is never the last cycle of a slot.
    assign w_slot_last   = !r_blank && (r_cnt == DWELL_LAST);
    assign w_frame_last  = w_slot_last &&
                           (((r_state == ST_SLOT0) && !w_two_slot) || (r_state == ST_SLOT1));
    assign w_req_ready_c = rst_n && ((r_state == ST_IDLE) || w_frame_last);
    assign w_xfer        = bus.req_valid && w_req_ready_c;
    assign bus.req_ready = w_req_ready_c;

    // Next-state logic.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_mask  = r_mask;
        w_nxt_cnt   = r_cnt + CNT_W'(1);
        w_nxt_blank = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_nxt_cnt = '0;
                if (w_xfer) begin
                    w_nxt_mask = bus.req_mask;
                    if (bus.req_mask != '0) w_nxt_state = ST_SLOT0;
                end
            end
            ST_SLOT0, ST_SLOT1: begin
                if (r_blank) begin
                    w_nxt_cnt = '0;
                end else if (w_frame_last) begin
                    w_nxt_cnt = '0;
                    if (w_xfer) begin
                        w_nxt_mask = bus.req_mask;
                        if (bus.req_mask != '0) begin
                            w_nxt_state = ST_SLOT0;
                            w_nxt_blank = BLANK_EN;
                        end else begin
                            w_nxt_state = ST_IDLE;
                        end
                    end else begin
                        w_nxt_state = ST_SLOT0;
                        w_nxt_blank = BLANK_EN;
                    end
                end else if (w_slot_last) begin
                    w_nxt_cnt   = '0;
                    w_nxt_state = ST_SLOT1;
                    w_nxt_blank = BLANK_EN;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    // Channel codes follow the current slot, so they trail the state by one edge.
    always_comb begin
        w_nxt_cha = IDLE_CODE;
        w_nxt_chb = IDLE_CODE;
        if (!r_blank) begin
            case (r_state)
                ST_SLOT0: begin
                    w_nxt_cha = w_s0a;
                    w_nxt_chb = w_s0b;
                end
                ST_SLOT1: begin
                    w_nxt_cha = w_s1a;
                    w_nxt_chb = w_s1b;
                end
                default: begin
                    w_nxt_cha = IDLE_CODE;
                    w_nxt_chb = IDLE_CODE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
            r_cnt   <= '0;
            r_blank <= 1'b0;
            r_cha   <= IDLE_CODE;
            r_chb   <= IDLE_CODE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_mask  <= w_nxt_mask;
            r_cnt   <= w_nxt_cnt;
            r_blank <= w_nxt_blank;
            r_cha   <= w_nxt_cha;
            r_chb   <= w_nxt_chb;
            r_busy  <= (w_nxt_state != ST_IDLE);
        end
    end

    assign {a, b, c} = r_cha;
    assign {d, e, f} = r_chb;
    assign busy      = r_busy;

endmodule

// File: tb/tb_led_code_encoder.sv
// Directed self-checking bench for led_code_encoder at DWELL=4; the blank
// sequence is exercised when LED_ENC_BLANK_EN is defined.
module tb_led_code_encoder;
    import led_enc_pkg::*;

    logic clk;
    logic rst_n;
    logic a, b, c, d, e, f, busy;
    logic [5:0] w_outs;
    int n_tests = 0;
    int n_fail  = 0;

    led_code_encoder_if u_if ();

    led_code_encoder #(.DWELL(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .e     (e),
        .f     (f),
        .busy  (busy)
    );

    assign w_outs = {a, b, c, d, e, f};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        u_if.req_valid = 1'b0;
        u_if.req_mask  = 4'b0000;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Presents a mask and returns at the negedge right after the accepting edge.
    task automatic send(input logic [3:0] m);
        int waited = 0;
        u_if.req_mask  = m;
        u_if.req_valid = 1'b1;
        while (!u_if.req_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!u_if.req_ready) check_eq("send_timeout", 8'd0, 8'd1);
        tick();
        u_if.req_valid = 1'b0;
    endtask

    function automatic logic [3:0] decode(input logic [2:0] code);
        case (code)
            3'b010:  decode = 4'b0001;
            3'b000:  decode = 4'b0010;
            3'b111:  decode = 4'b0100;
            3'b101:  decode = 4'b1000;
            default: decode = 4'b0000;
        endcase
    endfunction

    initial begin
        rst_n          = 1'b0;
        u_if.req_valid = 1'b0;
        u_if.req_mask  = 4'b0000;
        tick();
        tick();
        check_eq("rst_outs",  8'(w_outs), 8'h1b);
        check_eq("rst_busy",  8'(busy), 8'd0);
        check_eq("rst_ready", 8'(u_if.req_ready), 8'd0);
        rst_n = 1'b1;
        #1;
        check_eq("idle_ready", 8'(u_if.req_ready), 8'd1);
        check_eq("idle_busy",  8'(busy), 8'd0);
        check_eq("idle_outs",  8'(w_outs), 8'h1b);

`ifdef LED_ENC_BLANK_EN
        // Mask 0111: slot0 010/000, blank, slot1 111/011, blank -> period 10.
        send(4'b0111);
        check_eq("b_lat", 8'(w_outs), 8'h1b);
        for (int k = 1; k <= 25; k++) begin
            logic [5:0] exp;
            int m;
            tick();
            m = (k - 1) % 10;
            if (m < 4)                  exp = 6'b010_000;
            else if (m == 4 || m == 9)  exp = 6'b011_011;
            else                        exp = 6'b111_011;
            check_eq("b_0111", 8'(w_outs), 8'(exp));
        end
        do_reset();
`else
        // Single LED0: one-slot frame refreshing every 4 cycles.
        send(4'b0001);
        check_eq("m1_lat",   8'(w_outs), 8'h1b);
        check_eq("m1_busy",  8'(busy), 8'd1);
        check_eq("m1_ready", 8'(u_if.req_ready), 8'd0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_eq("m1_outs",  8'(w_outs), 8'b0001_0011);
            check_eq("m1_rdy_k", 8'(u_if.req_ready), 8'((k % 4) == 3));
        end

        // All four LEDs: two alternating slots of 4 cycles.
        do_reset();
        send(4'b1111);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check_eq("m15_outs", 8'(w_outs),
                     (((k - 1) / 4) % 2 == 0) ? 8'b0001_0000 : 8'b0011_1101);
        end

        // LEDs 1 and 3 share slot0; decoded LED set must stay 1010.
        do_reset();
        send(4'b1010);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_eq("m10_outs", 8'(w_outs), 8'b0000_0101);
            check_eq("m10_leds", 8'(decode({a, b, c}) | decode({d, e, f})), 8'b0000_1010);
        end

        // Mid-frame request stalls until the last SLOT1 cycle.
        do_reset();
        send(4'b1111);
        tick();
        u_if.req_mask  = 4'b0100;
        u_if.req_valid = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            check_eq("stall_rdy", 8'(u_if.req_ready), 8'd0);
            tick();
        end
        check_eq("stall_last", 8'(u_if.req_ready), 8'd1);
        tick();
        u_if.req_valid = 1'b0;
        check_eq("acc_prev", 8'(w_outs), 8'b0011_1101);
        tick();
        check_eq("acc_new",  8'(w_outs), 8'b0011_1011);

        // Reset in the third SLOT1 cycle aborts the frame.
        do_reset();
        send(4'b1111);
        for (int j = 1; j <= 6; j++) tick();
        check_eq("pre_abort", 8'(w_outs), 8'b0011_1101);
        rst_n = 1'b0;
        tick();
        check_eq("abort_outs",  8'(w_outs), 8'h1b);
        check_eq("abort_busy",  8'(busy), 8'd0);
        check_eq("abort_ready", 8'(u_if.req_ready), 8'd0);
        rst_n = 1'b1;
`endif

        // Zero-mask transfer keeps the encoder idle.
        #1;
        check_eq("z_ready", 8'(u_if.req_ready), 8'd1);
        send(4'b0000);
        check_eq("z_busy", 8'(busy), 8'd0);
        tick();
        tick();
        check_eq("z_busy2", 8'(busy), 8'd0);
        check_eq("z_outs",  8'(w_outs), 8'h1b);
        check_eq("z_ready2", 8'(u_if.req_ready), 8'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
